if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Decoupling queue between the IF stage and the ID stage. It consumes if_stage_out_t
//  records (inst, pc, pc4, branch-kind flags, prediction) from IF and buffers them in order.
//  It presents the oldest record to ID with a valid/ready handshake, and drives the IF stall
//  bit (if_stage_in_t.stall) back to IF when full. It is flushed by the EX redirect
//  (br_taken / misprediction), so no wrong-path instruction reaches ID.
// PARAMETERS
//  DEPTH   4              entries; power of two, >= 2
//  PTR_W   $clog2(DEPTH)  read/write pointer width (derived, not overridden)
//  CNT_W   PTR_W+1        occupancy width (derived)
// PORTS
//  clk            in   1        single clock; all state on rising edge
//  arst_n         in   1        asynchronous, active-low reset
//  if_out_i       in   132      if_stage_out_t from IF; held stable by IF while if_stall_o=1
//  if_valid_i     in   1        if_out_i carries a fetched instruction this cycle
//  if_stall_o     out  1        queue full; top level ORs it into if_stage_in_t.stall
//  flush_i        in   1        EX redirect (br_taken | misprediction); discard all entries
//  id_out_o       out  132      if_stage_out_t at queue head
//  id_valid_o     out  1        id_out_o is valid
//  id_ready_i     in   1        ID accepts the head this cycle
//  count_o        out  CNT_W    current occupancy, 0..DEPTH
//  flush_drop_o   out  16       saturating count of entries discarded by flushes
// BEHAVIOUR
//  - Reset (arst_n=0, async): wr_ptr=rd_ptr=0, count=0, storage cleared to 0, flush_drop=0.
//    Outputs: id_valid_o=0, if_stall_o=0, id_out_o=0, count_o=0, flush_drop_o=0.
//    Reset asserted mid-operation discards all entries immediately, with no drop counting.
//  - full = (count==DEPTH); empty = (count==0).
//  - push = if_valid_i & ~full & ~flush_i. pop = id_valid_o & id_ready_i.
//  - if_stall_o = full (combinational from the count register). It does not depend on
//    id_ready_i. No pop-when-full pass-through: a full queue always stalls IF for that cycle.
//  - id_valid_o = ~empty & ~flush_i. id_out_o = mem[rd_ptr], combinational read.
//  - Latency: a record pushed at edge N is visible at id_out_o after edge N. No same-cycle bypass.
//  - Push: mem[wr_ptr] <= if_out_i, and wr_ptr increments.
//  - Pop: rd_ptr increments.
//  - Pointers wrap modulo DEPTH through natural PTR_W overflow.
//  - Simultaneous push and pop (not full, not empty): count is unchanged, both pointers advance.
//  - Push and pop with count==1: the head is consumed and the new entry becomes the head after the edge.
//  - Flush has priority over push and pop.
//    - At the edge: wr_ptr=rd_ptr=0, count=0.
//    - The cycle's IF record is dropped, because it is wrong-path.
//    - flush_drop += count (pre-flush), saturating at 16'hFFFF.
//    - Flush on an empty queue changes nothing except the pointer reset.
//  - No FSM beyond occupancy. States are EMPTY / PARTIAL / FULL, implied by count:
//    - EMPTY -> PARTIAL on push.
//    - PARTIAL -> FULL on push without pop when count==DEPTH-1.
//    - FULL -> PARTIAL on pop.
//    - Any state -> EMPTY on flush.
//  - Stored records are never modified. All 132 bits round-trip bit-exact.
// STRUCTURE
//  - if_stage_out_t comes from if_stage_pkg, and entry width is $bits(if_stage_out_t).
//  - Add localparam IFQ_DEPTH_DEFAULT = 4 to if_stage_pkg.
//  - Flat module: storage array, two pointers, count register, drop counter.
//    No sub-module is warranted.
//  - Top-level wiring:
//    - if_stage_in_t.stall = hazard_stall | if_stall_o.
//    - flush_i = if_stage_in_frm_ex_t.br_taken | misprediction.
// TESTING
//  - Reset: hold arst_n=0 with random inputs -> id_valid_o=0, if_stall_o=0, count_o=0,
//    id_out_o=0. Deassert -> no change until the first push.
//  - Order: push pc=0x100,0x104,0x108 with id_ready_i=0, then ready=1 ->
//    id_out_o.pc is 0x100,0x104,0x108 on consecutive cycles. count_o goes 3,2,1,0.
//  - Full: DEPTH=4, push 5 records with ready=0 -> after the 4th edge count_o=4 and
//    if_stall_o=1. The 5th record (pc=0x110) is held, not lost. One pop -> 0x110 enters
//    on the next edge.
//  - Wrap: 10 cycles of continuous push+pop with ready=1 -> count_o stays at 1.
//    pcs emerge in order 0x0..0x24 step 4. Pointers wrap twice.
//  - Flush: 3 entries queued, flush_i=1 with if_valid_i=1 (pc=0x200) ->
//    - During the flush cycle: id_valid_o=0.
//    - Next cycle: count_o=0, 0x200 not stored, flush_drop_o=3.
//    - Next push pc=0x300 is the head.
//  - Saturation and priority: force flush_drop to 16'hFFFE, then flush with 3 entries ->
//    flush_drop_o=16'hFFFF. Flush with push, pop and ready all high on the same edge ->
//    the queue is empty afterwards.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared IF-stage types: the record IF hands downstream and the fetch-queue default depth.
package if_stage_pkg;

   localparam int IFQ_DEPTH_DEFAULT = 4;

   // 132-bit record: instruction word, its pc, pc+4, branch-kind flags and the IF prediction.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        pred_taken;
      logic [31:0] pred_target;
   } if_stage_out_t;

   localparam int IF_STAGE_OUT_W = $bits(if_stage_out_t);

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order IF->ID decoupling queue: stalls IF when full, flushed by the EX redirect.
// Top level: if_stage_in_t.stall = hazard_stall | if_stall_o; flush_i = br_taken | misprediction.
module if_fetch_queue
   import if_stage_pkg::*;
#(
   parameter  int DEPTH = IFQ_DEPTH_DEFAULT,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  if_stage_out_t     if_out_i,
   input  logic              if_valid_i,
   output logic              if_stall_o,
   input  logic              flush_i,
   output if_stage_out_t     id_out_o,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [15:0]       flush_drop_o
);

   if_stage_out_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [15:0]      flush_drop_q;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A redirect masks both sides, so no wrong-path record enters or reaches ID that cycle.
   assign push       = if_valid_i & ~full & ~flush_i;
   assign id_valid_o = ~empty & ~flush_i;
   assign pop        = id_valid_o & id_ready_i;

   assign if_stall_o   = full;
   assign id_out_o     = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign flush_drop_o = flush_drop_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         flush_drop_q <= '0;
         // NOTE: storage is reset too, so id_out_o reads a defined zero record out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         flush_drop_q <= sat_add16(flush_drop_q, 16'(count_q));
      end else begin
         // NOTE: non-blocking updates let every branch read pre-edge state consistently.
         if (push) begin
            mem_q[wr_ptr_q] <= if_out_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: queue-based reference model plus directed literal checks.
module tb_if_fetch_queue;
   import if_stage_pkg::*;

   localparam int DEPTH = IFQ_DEPTH_DEFAULT;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             arst_n;
   if_stage_out_t    if_out;
   logic             if_valid;
   logic             if_stall;
   logic             flush;
   if_stage_out_t    id_out;
   logic             id_valid;
   logic             id_ready;
   logic [CNT_W-1:0] count;
   logic [15:0]      flush_drop;

   int total = 0;
   int bad   = 0;

   if_stage_out_t m_q[$];
   int            m_drop = 0;

   if_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .if_out_i     (if_out),
      .if_valid_i   (if_valid),
      .if_stall_o   (if_stall),
      .flush_i      (flush),
      .id_out_o     (id_out),
      .id_valid_o   (id_valid),
      .id_ready_i   (id_ready),
      .count_o      (count),
      .flush_drop_o (flush_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic if_stage_out_t mk_rec(input logic [31:0] pc);
      if_stage_out_t r;
      r.inst        = $urandom;
      r.pc          = pc;
      r.pc4         = pc + 32'd4;
      r.is_branch   = 1'($urandom_range(0, 1));
      r.is_jal      = 1'($urandom_range(0, 1));
      r.is_jalr     = 1'($urandom_range(0, 1));
      r.pred_taken  = 1'($urandom_range(0, 1));
      r.pred_target = $urandom;
      return r;
   endfunction

   task automatic set_ctl(input logic v, input logic r, input logic f);
      if_valid = v;
      id_ready = r;
      flush    = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Reference: a FIFO of records plus a drop tally, advanced once per rising edge.
   task automatic model_edge();
      int  s;
      bit  do_push;
      bit  do_pop;
      if (flush) begin
         s      = m_drop + m_q.size();
         m_drop = (s > 65535) ? 65535 : s;
         m_q.delete();
      end else begin
         do_pop  = (m_q.size() > 0) && id_ready;
         do_push = if_valid && (m_q.size() < DEPTH);
         if (do_pop)  void'(m_q.pop_front());
         if (do_push) m_q.push_back(if_out);
      end
   endtask

   task automatic compare();
      logic exp_valid;
      exp_valid = (m_q.size() != 0) && !flush;
      check("id_valid",   132'(id_valid),   132'(exp_valid));
      check("if_stall",   132'(if_stall),   132'(m_q.size() == DEPTH));
      check("count",      132'(count),      132'(m_q.size()));
      check("flush_drop", 132'(flush_drop), 132'(m_drop));
      if (exp_valid) check("id_out", 132'(id_out), 132'(m_q[0]));
   endtask

   initial begin
      arst_n   = 1'b0;
      if_valid = 1'b0;
      id_ready = 1'b0;
      flush    = 1'b0;
      if_out   = '0;

      fork
         forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
               m_q.delete();
               m_drop = 0;
            end else begin
               model_edge();
            end
         end
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      // Reset held with random inputs: outputs stay at zero.
      for (int i = 0; i < 3; i++) begin
         if_out = mk_rec($urandom);
         set_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
         settle();
         check("rst_valid", 132'(id_valid),   132'(0));
         check("rst_stall", 132'(if_stall),   132'(0));
         check("rst_count", 132'(count),      132'(0));
         check("rst_idout", 132'(id_out),     132'(0));
         check("rst_drop",  132'(flush_drop), 132'(0));
      end
      set_ctl(1'b0, 1'b0, 1'b0);
      arst_n = 1'b1;
      tick();
      tick();
      check("post_rst_count", 132'(count),    132'(0));
      check("post_rst_valid", 132'(id_valid), 132'(0));

      // In-order delivery.
      for (int i = 0; i < 3; i++) begin
         if_out = mk_rec(32'h100 + 32'(4 * i));
         set_ctl(1'b1, 1'b0, 1'b0);
         tick();
      end
      set_ctl(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle();
         check("order_pc",    132'(id_out.pc), 132'(32'h100 + 32'(4 * i)));
         check("order_count", 132'(count),     132'(3 - i));
         tick();
      end
      settle();
      check("order_empty", 132'(count), 132'(0));

      // Full: 5th record is held by the stall and enters after a pop.
      for (int i = 0; i < 4; i++) begin
         if_out = mk_rec(32'h100 + 32'(4 * i));
         set_ctl(1'b1, 1'b0, 1'b0);
         tick();
      end
      if_out = mk_rec(32'h110);
      settle();
      check("full_count", 132'(count),    132'(4));
      check("full_stall", 132'(if_stall), 132'(1));
      tick();
      settle();
      check("full_hold_count", 132'(count), 132'(4));
      set_ctl(1'b1, 1'b1, 1'b0);
      settle();
      check("full_stall_ready", 132'(if_stall), 132'(1));
      tick();
      settle();
      check("full_pop_count", 132'(count),     132'(3));
      check("full_pop_head",  132'(id_out.pc), 132'(32'h104));
      set_ctl(1'b1, 1'b0, 1'b0);
      tick();
      settle();
      check("full_refill_count", 132'(count), 132'(4));
      set_ctl(1'b0, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) begin
         settle();
         check("full_drain_pc", 132'(id_out.pc), 132'(32'h100 + 32'(4 * i)));
         tick();
      end
      settle();
      check("full_drain_empty", 132'(count), 132'(0));

      // Wrap: continuous push+pop keeps one entry in flight.
      for (int i = 0; i <= 10; i++) begin
         if_out = mk_rec(32'(4 * i));
         set_ctl(1'(i < 10), 1'b1, 1'b0);
         settle();
         if (i > 0) begin
            check("wrap_pc",    132'(id_out.pc), 132'(32'(4 * (i - 1))));
            check("wrap_count", 132'(count),     132'(1));
         end
         tick();
      end
      settle();
      check("wrap_empty", 132'(count), 132'(0));

      // Flush with a wrong-path IF record on the same edge.
      for (int i = 0; i < 3; i++) begin
         if_out = mk_rec(32'h1A0 + 32'(4 * i));
         set_ctl(1'b1, 1'b0, 1'b0);
         tick();
      end
      if_out = mk_rec(32'h200);
      set_ctl(1'b1, 1'b1, 1'b1);
      settle();
      check("flush_cycle_valid", 132'(id_valid), 132'(0));
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
      settle();
      check("flush_count", 132'(count),      132'(0));
      check("flush_drop3", 132'(flush_drop), 132'(3));
      if_out = mk_rec(32'h300);
      set_ctl(1'b1, 1'b0, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
      settle();
      check("flush_next_valid", 132'(id_valid),  132'(1));
      check("flush_next_head",  132'(id_out.pc), 132'(32'h300));
      set_ctl(1'b0, 1'b1, 1'b0);
      tick();

      // Saturation of the drop counter.
      force dut.flush_drop_q = 16'hFFFE;
      m_drop = 32'hFFFE;
      settle();
      release dut.flush_drop_q;
      for (int i = 0; i < 3; i++) begin
         if_out = mk_rec(32'h400 + 32'(4 * i));
         set_ctl(1'b1, 1'b0, 1'b0);
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
      settle();
      check("sat_drop", 132'(flush_drop), 132'(16'hFFFF));
      for (int i = 0; i < 2; i++) begin
         if_out = mk_rec(32'h500 + 32'(4 * i));
         set_ctl(1'b1, 1'b0, 1'b0);
         tick();
      end
      // Flush wins over a simultaneous push and pop.
      if_out = mk_rec(32'h600);
      set_ctl(1'b1, 1'b1, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
      settle();
      check("prio_count", 132'(count),      132'(0));
      check("prio_valid", 132'(id_valid),   132'(0));
      check("sat_hold",   132'(flush_drop), 132'(16'hFFFF));

      // Randomized traffic against the model, with one mid-cycle async reset.
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      if_valid = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!(m_q.size() == DEPTH && if_valid)) begin
            if_out   = mk_rec($urandom);
            if_valid = ($urandom_range(0, 9) < 7);
         end
         id_ready = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 19) == 0);
         if (c == 1000) begin
            #2 arst_n = 1'b0;
            #4 arst_n = 1'b1;
         end
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
